// File: rtl/light_countdown_display.sv
// Per-road seconds-remaining countdown (3-digit BCD) derived from the traffic-light codes, plus sticky light-code supervision.
// Optional build macro FAULT_BLINK_EN: when defined, blank toggles on every tick while fault is latched.
module light_countdown_display #(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  highway_light,
   input  logic [2:0]  country_light,
   input  logic [6:0]  Timeout,
   input  logic [3:0]  timeout,
   output logic [11:0] h_bcd,
   output logic [11:0] c_bcd,
   output logic        tick,
   output logic        fault,
   output logic        blank
);

   localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic          fault_q, fault_d;
   logic [1:0]    chg;
   logic          any_chg;
   logic [5:0]    lights;
   logic [23:0]   bcd_all;

   function automatic logic is_legal(input logic [2:0] l);
      return (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
   endfunction

   function automatic logic [CNT_W-1:0] reload_val(input logic [2:0] l,
                                                   input logic [6:0] long_s,
                                                   input logic [3:0] short_s);
      case (l)
         3'b001:  return CNT_W'(long_s);
         3'b010:  return CNT_W'(short_s);
         3'b100:  return CNT_W'(long_s) + CNT_W'(short_s);
         default: return '0;
      endcase
   endfunction

   function automatic logic [11:0] to_bcd(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] hun, ten, uni;
      hun = v / CNT_W'(100);
      ten = (v / CNT_W'(10)) % CNT_W'(10);
      uni = v % CNT_W'(10);
      return {hun[3:0], ten[3:0], uni[3:0]};
   endfunction

   assign lights  = {country_light, highway_light};
   assign any_chg = |chg;

   // A light change on either road restarts the second so each phase begins with a full one.
   always_comb begin
      presc_d = presc_q + PW'(1);
      tick_d  = 1'b0;
      if (any_chg) begin
         presc_d = '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         tick_d  = 1'b1;
      end
      fault_d = fault_q | ~is_legal(highway_light) | ~is_legal(country_light)
              | (~highway_light[2] & ~country_light[2]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         fault_q <= fault_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_road
         logic [2:0]       light, prev_q, prev_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic [11:0]      bcd_q, bcd_d;

         assign light   = lights[gi*3 +: 3];
         assign chg[gi] = (light != prev_q);

         // Load beats a coincident tick; the count parks at zero while a phase is extended.
         always_comb begin
            prev_d = light;
            cnt_d  = cnt_q;
            if (!fault_q) begin
               if (chg[gi]) begin
                  cnt_d = reload_val(light, Timeout, timeout);
               end else if (tick_d && (cnt_q != '0)) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            bcd_d = fault_d ? 12'h000 : to_bcd(cnt_q);
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               prev_q <= 3'b000;
               cnt_q  <= '0;
               bcd_q  <= 12'h000;
            end else begin
               prev_q <= prev_d;
               cnt_q  <= cnt_d;
               bcd_q  <= bcd_d;
            end
         end

         assign bcd_all[gi*12 +: 12] = bcd_q;
      end
   endgenerate

   assign h_bcd = bcd_all[11:0];
   assign c_bcd = bcd_all[23:12];
   assign tick  = tick_q;
   assign fault = fault_q;

`ifdef FAULT_BLINK_EN
   logic blank_q, blank_d;

   always_comb begin
      blank_d = 1'b0;
      if (fault_q) blank_d = tick_d ? ~blank_q : blank_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) blank_q <= 1'b0;
      else        blank_q <= blank_d;
   end

   assign blank = blank_q;
`else
   assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_light_countdown_display.sv
// Bench for light_countdown_display: directed vector table from the test plan plus randomized light sequences vs. a phase-level model.
module tb_light_countdown_display;

   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  highway_light = 3'b001;
   logic [2:0]  country_light = 3'b100;
   logic [6:0]  Timeout = 7'd10;
   logic [3:0]  timeout = 4'd3;
   logic [11:0] h_bcd, c_bcd;
   logic        tick, fault, blank;

   int vectors = 0;
   int miscompares = 0;

   light_countdown_display #(.TICK_DIV(TICK_DIV), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .highway_light(highway_light), .country_light(country_light),
      .Timeout(Timeout), .timeout(timeout),
      .h_bcd(h_bcd), .c_bcd(c_bcd), .tick(tick), .fault(fault), .blank(blank)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // Phase-level model: seconds remaining per road, second boundaries counted from the last light change.
   int         m_edge, m_sync;
   logic [2:0] m_prev [2];
   int         m_rem  [2];
   int         m_disp [2];
   bit         m_fault, m_tick, m_blank;

   function automatic bit legal_code(input logic [2:0] l);
      return (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
   endfunction

   function automatic int phase_len(input logic [2:0] l, input int long_s, input int short_s);
      if (l == 3'b001) return long_s;
      if (l == 3'b010) return short_s;
      if (l == 3'b100) return long_s + short_s;
      return 0;
   endfunction

   function automatic logic [11:0] dec3(input int v);
      logic [11:0] r;
      r[11:8] = 4'(v / 100);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   task automatic model_reset();
      m_edge = 0; m_sync = 0;
      m_fault = 0; m_tick = 0; m_blank = 0;
      for (int r = 0; r < 2; r++) begin
         m_prev[r] = 3'b000; m_rem[r] = 0; m_disp[r] = 0;
      end
   endtask

   task automatic model_edge();
      logic [2:0] l [2];
      bit ch [2];
      bit any, tk, nf;
      l[0] = highway_light; l[1] = country_light;
      ch[0] = (l[0] != m_prev[0]);
      ch[1] = (l[1] != m_prev[1]);
      any = ch[0] || ch[1];
      m_edge++;
      tk = !any && ((m_edge - m_sync) % TICK_DIV == 0);
      if (any) m_sync = m_edge;
      nf = m_fault || !legal_code(l[0]) || !legal_code(l[1]) || (!l[0][2] && !l[1][2]);
      for (int r = 0; r < 2; r++) begin
         m_disp[r] = nf ? 0 : m_rem[r];
         if (!m_fault) begin
            if (ch[r]) m_rem[r] = phase_len(l[r], int'(Timeout), int'(timeout));
            else if (tk && m_rem[r] > 0) m_rem[r] = m_rem[r] - 1;
         end
         m_prev[r] = l[r];
      end
`ifdef FAULT_BLINK_EN
      if (!m_fault) m_blank = 0;
      else if (tk) m_blank = !m_blank;
`else
      m_blank = 0;
`endif
      m_fault = nf;
      m_tick  = tk;
   endtask

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic check_model();
      chk("model h_bcd", h_bcd, dec3(m_disp[0]));
      chk("model c_bcd", c_bcd, dec3(m_disp[1]));
      chk("model tick",  {11'd0, tick},  {11'd0, m_tick});
      chk("model fault", {11'd0, fault}, {11'd0, m_fault});
      chk("model blank", {11'd0, blank}, {11'd0, m_blank});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic check_cleared(input string nm);
      chk({nm, " h_bcd"}, h_bcd, 12'h000);
      chk({nm, " c_bcd"}, c_bcd, 12'h000);
      chk({nm, " tick"},  {11'd0, tick},  12'h000);
      chk({nm, " fault"}, {11'd0, fault}, 12'h000);
      chk({nm, " blank"}, {11'd0, blank}, 12'h000);
   endtask

   // Called at a falling edge: asserts reset, checks the immediate clear, releases at a later falling edge.
   task automatic do_reset(input int ncyc);
      reset = 1'b0;
      #1;
      check_cleared("reset");
      model_reset();
      repeat (ncyc) @(negedge clk);
      check_cleared("in-reset");
      reset = 1'b1;
      $display("reset released at %0t", $time);
   endtask

   typedef struct {
      logic [2:0]  hl, cl;
      logic [6:0]  lt;
      logic [3:0]  st;
      int          n;
      logic [11:0] eh, ec;
      logic        et, ef;
   } vec_t;

   vec_t tbl [12];

   initial begin
      // Hand-derived expectations for TICK_DIV=4, edges counted from reset release.
      tbl[0]  = '{3'b001, 3'b100, 7'd10,  4'd3,  2, 12'h010, 12'h013, 1'b0, 1'b0};
      tbl[1]  = '{3'b001, 3'b100, 7'd10,  4'd3,  3, 12'h010, 12'h013, 1'b1, 1'b0};
      tbl[2]  = '{3'b001, 3'b100, 7'd10,  4'd3,  1, 12'h009, 12'h012, 1'b0, 1'b0};
      tbl[3]  = '{3'b001, 3'b100, 7'd10,  4'd3, 44, 12'h000, 12'h001, 1'b0, 1'b0};
      tbl[4]  = '{3'b001, 3'b100, 7'd10,  4'd3,  2, 12'h000, 12'h001, 1'b0, 1'b0};
      tbl[5]  = '{3'b010, 3'b100, 7'd10,  4'd3,  1, 12'h000, 12'h001, 1'b0, 1'b0};
      tbl[6]  = '{3'b010, 3'b100, 7'd10,  4'd3,  1, 12'h003, 12'h001, 1'b0, 1'b0};
      tbl[7]  = '{3'b010, 3'b100, 7'd10,  4'd3,  3, 12'h003, 12'h001, 1'b1, 1'b0};
      tbl[8]  = '{3'b010, 3'b100, 7'd10,  4'd3,  1, 12'h002, 12'h000, 1'b0, 1'b0};
      tbl[9]  = '{3'b100, 3'b100, 7'd127, 4'd15, 2, 12'h142, 12'h000, 1'b0, 1'b0};
      tbl[10] = '{3'b001, 3'b001, 7'd127, 4'd15, 1, 12'h000, 12'h000, 1'b0, 1'b1};
      tbl[11] = '{3'b001, 3'b100, 7'd127, 4'd15, 5, 12'h000, 12'h000, 1'b1, 1'b1};

      model_reset();
      repeat (3) @(negedge clk);
      check_cleared("power-on reset");
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         highway_light = tbl[i].hl;
         country_light = tbl[i].cl;
         Timeout       = tbl[i].lt;
         timeout       = tbl[i].st;
         repeat (tbl[i].n) step();
         chk($sformatf("vec%0d h_bcd", i), h_bcd, tbl[i].eh);
         chk($sformatf("vec%0d c_bcd", i), c_bcd, tbl[i].ec);
         chk($sformatf("vec%0d tick", i),  {11'd0, tick},  {11'd0, tbl[i].et});
         chk($sformatf("vec%0d fault", i), {11'd0, fault}, {11'd0, tbl[i].ef});
         $display("vec%0d hw=%b cr=%b T=%0d t=%0d -> h=%h c=%h tick=%b fault=%b blank=%b",
                  i, tbl[i].hl, tbl[i].cl, tbl[i].lt, tbl[i].st, h_bcd, c_bcd, tick, fault, blank);
      end

      // Fault stays latched until reset; mid-phase reset then restarts from the current codes.
      repeat (8) step();
      chk("sticky fault", {11'd0, fault}, 12'h001);
      do_reset(2);
      highway_light = 3'b100; country_light = 3'b001; Timeout = 7'd5; timeout = 4'd2;
      repeat (2) step();
      chk("post-reset h_bcd", h_bcd, 12'h007);
      chk("post-reset c_bcd", c_bcd, 12'h005);

      for (int it = 0; it < 60; it++) begin
         int sel;
         if (it % 15 == 14) do_reset($urandom_range(1, 3));
         sel = $urandom_range(0, 24);
         case (sel % 5)
            0: begin highway_light = 3'b001; country_light = 3'b100; end
            1: begin highway_light = 3'b010; country_light = 3'b100; end
            2: begin highway_light = 3'b100; country_light = 3'b100; end
            3: begin highway_light = 3'b100; country_light = 3'b001; end
            default: begin highway_light = 3'b100; country_light = 3'b010; end
         endcase
         if (sel == 24) begin
            highway_light = 3'($urandom_range(0, 7));
            country_light = 3'($urandom_range(0, 7));
         end
         Timeout = 7'($urandom_range(0, 127));
         timeout = 4'($urandom_range(0, 15));
         repeat ($urandom_range(1, 30)) step();
         $display("rand%0d hw=%b cr=%b T=%0d t=%0d -> h=%h c=%h tick=%b fault=%b blank=%b",
                  it, highway_light, country_light, Timeout, timeout, h_bcd, c_bcd, tick, fault, blank);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
